// File: rtl/mimc_mulmod.sv
// Sequential modular multiplier over the BN254 scalar field used by Dark Forest
// MiMC: out_product = (in_a * in_b) mod p. Radix-2, MSB-first interleaved
// multiply/reduce, one multiplier bit per clock, 256 steps per operation.

// Source of the 256-bit field prime p.
module mimc_prime (
  output logic [255:0] o_p
);
  assign o_p = 256'h30644e72e131a029b85045b68181585d2833e84879b9709143e1f593f0000001;
endmodule

module mimc_mulmod #(
  parameter int TAG_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [255:0]         in_a,
  input  logic [255:0]         in_b,
  input  logic [TAG_WIDTH-1:0] in_tag,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [255:0]         out_product,
  output logic [TAG_WIDTH-1:0] out_tag
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t                 r_state;
  state_t                 w_state_nxt;
  logic [255:0]           w_p;
  logic [255:0]           r_a;
  logic [255:0]           r_b;
  logic [255:0]           r_acc;
  logic [7:0]             r_cnt;
  logic [TAG_WIDTH-1:0]   r_tag;

  // Datapath for one interleaved step.
  logic [256:0]           w_dbl;
  logic                   w_dbl_ge;
  logic [255:0]           w_t;
  logic [255:0]           w_addend;
  logic [256:0]           w_sum;
  logic                   w_sum_ge;
  logic [255:0]           w_acc_nxt;

  mimc_prime u_prime (
    .o_p (w_p)
  );

  // Doubling stage: t = 2*acc, one conditional subtract of p. For in-range
  // operands the reduced value is < p, so it fits in 256 bits and the
  // subtraction may be done modulo 2^256.
  assign w_dbl    = {r_acc, 1'b0};
  assign w_dbl_ge = (w_dbl >= {1'b0, w_p});
  assign w_t      = w_dbl_ge ? (w_dbl[255:0] - w_p) : w_dbl[255:0];

  // Accumulate stage: u = t + (b[cnt] ? a : 0), one conditional subtract of p.
  assign w_addend  = r_b[r_cnt] ? r_a : 256'd0;
  assign w_sum     = {1'b0, w_t} + {1'b0, w_addend};
  assign w_sum_ge  = (w_sum >= {1'b0, w_p});
  assign w_acc_nxt = w_sum_ge ? (w_sum[255:0] - w_p) : w_sum[255:0];

  // Handshake outputs depend on state only; in_ready is also held low in reset.
  assign in_ready    = reset_n && (r_state == S_IDLE);
  assign out_valid   = (r_state == S_DONE);
  assign out_product = r_acc;
  assign out_tag     = r_tag;

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of block evaluation order.
    if (!reset_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic: accept in IDLE, 256 steps in RUN, hold in DONE until taken.
  always_comb begin
    // NOTE: default first so every path assigns w_state_nxt and no latch is inferred.
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE: if (in_valid)      w_state_nxt = S_RUN;
      S_RUN:  if (r_cnt == 8'd0) w_state_nxt = S_DONE;
      S_DONE: if (out_ready)     w_state_nxt = S_IDLE;
      default:                   w_state_nxt = S_IDLE;
    endcase
  end

  // Operand capture at the accepting edge and accumulator/counter update in RUN.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_a   <= 256'd0;
      r_b   <= 256'd0;
      r_acc <= 256'd0;
      r_cnt <= 8'd0;
      r_tag <= '0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_a   <= in_a;
            r_b   <= in_b;
            r_tag <= in_tag;
            r_acc <= 256'd0;
            r_cnt <= 8'd255;
          end
        end
        S_RUN: begin
          r_acc <= w_acc_nxt;
          if (r_cnt != 8'd0) begin
            r_cnt <= r_cnt - 8'd1;
          end
        end
        default: begin
          // DONE holds the result and tag stable until the transfer.
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mimc_mulmod.sv
// Self-checking bench for mimc_mulmod: directed corner cases, backpressure,
// mid-operation reset, out-of-range operands and random field elements
// compared against a bignum (a*b) mod p reference.
module tb_mimc_mulmod;

  localparam int TW = 8;
  localparam logic [255:0] P =
    256'h30644e72e131a029b85045b68181585d2833e84879b9709143e1f593f0000001;
  localparam int N_RAND = 150;

  logic          clk;
  logic          reset_n;
  logic          in_valid;
  logic          in_ready;
  logic [255:0]  in_a;
  logic [255:0]  in_b;
  logic [TW-1:0] in_tag;
  logic          out_valid;
  logic          out_ready;
  logic [255:0]  out_product;
  logic [TW-1:0] out_tag;

  int n_checks = 0;
  int n_fail   = 0;

  mimc_mulmod #(.TAG_WIDTH(TW)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_a        (in_a),
    .in_b        (in_b),
    .in_tag      (in_tag),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_product (out_product),
    .out_tag     (out_tag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change and outputs are sampled 1 time unit after each rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%h, expected 0x%h", tag, obs, exp);
    end
  endtask

  // Reference: plain bignum multiply then modulo.
  function automatic logic [255:0] ref_mulmod(input logic [255:0] a, input logic [255:0] b);
    logic [511:0] prod;
    prod = {256'd0, a} * {256'd0, b};
    prod = prod % {256'd0, P};
    return prod[255:0];
  endfunction

  function automatic logic [255:0] rand_fe();
    logic [255:0] v;
    for (int i = 0; i < 8; i++) v[i*32 +: 32] = $urandom;
    v = v % P;
    return v;
  endfunction

  // Present an operand pair, wait (bounded) for in_ready, pass the accepting
  // edge, then scramble the inputs to show they were sampled only at that edge.
  task automatic send(input string name, input logic [255:0] a, input logic [255:0] b,
                      input logic [TW-1:0] tag);
    int guard;
    guard    = 0;
    in_a     = a;
    in_b     = b;
    in_tag   = tag;
    in_valid = 1'b1;
    while (in_ready !== 1'b1 && guard < 1000) begin
      tick();
      guard++;
    end
    check({name, "_ready_before_accept"}, 256'(in_ready), 256'd1);
    tick();
    in_valid = 1'b0;
    in_a     = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    in_b     = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    in_tag   = TW'($urandom);
    check({name, "_busy_after_accept"}, 256'(in_ready), 256'd0);
  endtask

  // Called right after send(): checks the 256-cycle latency, optionally holds
  // out_ready low for `gap` cycles, checks result and tag, then takes the result.
  task automatic receive(input string name, input logic [255:0] exp_p,
                         input logic [TW-1:0] exp_tag, input int gap);
    int n;
    n = 0;
    while (out_valid !== 1'b1 && n < 400) begin
      tick();
      n++;
    end
    check({name, "_latency"}, 256'(n), 256'd256);
    for (int i = 0; i < gap; i++) tick();
    check({name, "_valid_held"}, 256'(out_valid), 256'd1);
    check({name, "_product"}, out_product, exp_p);
    check({name, "_tag"}, 256'(out_tag), 256'(exp_tag));
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check({name, "_idle_ready"}, 256'(in_ready), 256'd1);
    check({name, "_idle_valid"}, 256'(out_valid), 256'd0);
  endtask

  initial begin
    logic [255:0]  a;
    logic [255:0]  b;
    logic [255:0]  x;
    logic [511:0]  wide;
    logic [255:0]  exp_r;
    logic [TW-1:0] tg;
    int            n;
    int            seen;

    reset_n   = 1'b0;
    in_valid  = 1'b0;
    in_a      = 256'd0;
    in_b      = 256'd0;
    in_tag    = '0;
    out_ready = 1'b0;

    // Reset state.
    #2;
    check("rst_in_ready", 256'(in_ready), 256'd0);
    check("rst_out_valid", 256'(out_valid), 256'd0);
    check("rst_out_product", out_product, 256'd0);
    check("rst_out_tag", 256'(out_tag), 256'd0);
    tick();
    tick();
    reset_n = 1'b1;
    #1;
    check("rst_release_ready", 256'(in_ready), 256'd1);

    // Small product, tag return, exact latency.
    send("small", 256'd3, 256'd5, 8'hA5);
    receive("small", 256'd15, 8'hA5, 0);

    // (p-1)^2 = 1 mod p.
    send("pm1_sq", P - 256'd1, P - 256'd1, 8'h01);
    receive("pm1_sq", 256'd1, 8'h01, 0);

    // (p-1)*2 = p-2 mod p.
    send("pm1_x2", P - 256'd1, 256'd2, 8'h02);
    receive("pm1_x2", P - 256'd2, 8'h02, 0);

    // (2^255 mod p) * 2 = 2^256 mod p (multiplicand reduced to stay in range).
    wide  = (512'd1 << 255) % {256'd0, P};
    a     = wide[255:0];
    wide  = (512'd1 << 256) % {256'd0, P};
    exp_r = wide[255:0];
    send("pow256", a, 256'd2, 8'h03);
    receive("pow256", exp_r, 8'h03, 0);

    // Zero operands and identity.
    send("zero_a", 256'd0, P - 256'd1, 8'h04);
    receive("zero_a", 256'd0, 8'h04, 0);
    send("zero_b", P - 256'd1, 256'd0, 8'h05);
    receive("zero_b", 256'd0, 8'h05, 0);
    x = 256'h1234567890abcdef_fedcba0987654321_0f1e2d3c4b5a6978_8796a5b4c3d2abcd;
    send("ident", 256'd1, x, 8'h06);
    receive("ident", x, 8'h06, 0);

    // Backpressure with in_valid held high for a second operation.
    a = rand_fe();
    b = rand_fe();
    send("bp1", 256'd11, 256'd13, 8'h77);
    in_valid = 1'b1;
    in_a     = a;
    in_b     = b;
    in_tag   = 8'h88;
    n = 0;
    while (out_valid !== 1'b1 && n < 400) begin
      tick();
      n++;
    end
    check("bp1_latency", 256'(n), 256'd256);
    for (int i = 0; i < 10; i++) begin
      check("bp_valid_held", 256'(out_valid), 256'd1);
      check("bp_in_ready_low", 256'(in_ready), 256'd0);
      check("bp_product_stable", out_product, 256'd143);
      check("bp_tag_stable", 256'(out_tag), 256'h77);
      tick();
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("bp_idle_ready", 256'(in_ready), 256'd1);
    check("bp_idle_valid", 256'(out_valid), 256'd0);
    tick();
    in_valid = 1'b0;
    check("bp2_busy_after_accept", 256'(in_ready), 256'd0);
    receive("bp2", ref_mulmod(a, b), 8'h88, 0);

    // Reset in the middle of RUN: the aborted operation must never complete.
    send("rst_op", rand_fe(), rand_fe(), 8'h99);
    for (int i = 0; i < 100; i++) tick();
    reset_n = 1'b0;
    #1;
    check("rst_mid_in_ready", 256'(in_ready), 256'd0);
    check("rst_mid_out_valid", 256'(out_valid), 256'd0);
    tick();
    tick();
    reset_n = 1'b1;
    #1;
    check("rst_mid_release_ready", 256'(in_ready), 256'd1);
    seen = 0;
    for (int i = 0; i < 300; i++) begin
      tick();
      if (out_valid === 1'b1) seen++;
    end
    check("rst_mid_no_result", 256'(seen), 256'd0);
    send("after_rst", 256'd7, 256'd9, 8'h3C);
    receive("after_rst", 256'd63, 8'h3C, 0);

    // Operands >= p: value unspecified, timing and known outputs required.
    send("oor", {256{1'b1}}, {256{1'b1}}, 8'h5A);
    n = 0;
    while (out_valid !== 1'b1 && n < 400) begin
      tick();
      n++;
    end
    check("oor_latency", 256'(n), 256'd256);
    check("oor_no_x", 256'($isunknown({out_product, out_tag})), 256'd0);
    check("oor_tag", 256'(out_tag), 256'h5A);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("oor_idle_ready", 256'(in_ready), 256'd1);

    // Random in-range pairs with random gaps on both sides.
    for (int k = 0; k < N_RAND; k++) begin
      a  = rand_fe();
      b  = rand_fe();
      tg = TW'($urandom);
      n  = int'($urandom_range(0, 3));
      for (int i = 0; i < n; i++) tick();
      send("rand", a, b, tg);
      receive("rand", ref_mulmod(a, b), tg, int'($urandom_range(0, 3)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Global bound so the run always ends on its own.
  initial begin
    #3_000_000;
    $display("FAIL watchdog: observed no completion, expected finish before 3 ms");
    $fatal(1, "simulation time limit reached");
  end

endmodule
